// File: rtl/microwave_timer_ctrl_if.sv
// Front-panel bundle for microwave_timer_ctrl: keypad and button requests in,
// BCD display digits and magnetron enable out.
interface microwave_timer_ctrl_if;
  logic       key_valid;
  logic [3:0] key_value;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       heat_on;
  logic       done;

  modport master (
    output key_valid, key_value, start, stop, door_closed,
    input  mins, sec_tens, sec_ones, heat_on, done
  );

  modport slave (
    input  key_valid, key_value, start, stop, door_closed,
    output mins, sec_tens, sec_ones, heat_on, done
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Oven cooking timer: keypad M:SS entry, 1 Hz countdown, pause/resume/cancel.
// Optional QUICK_START_EN: start at 0:00 with the door shut loads 0:30 and runs.
module microwave_timer_ctrl #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  microwave_timer_ctrl_if.slave  panel
);

  // state | meaning
  // IDLE  | keypad entry, waiting for start
  // RUN   | counting down, heat on
  // PAUSE | countdown frozen, prescaler held
  // DONE  | reached 0:00, waiting for any key/button
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  localparam int            PW        = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

  state_e        state_q, state_d;
  logic [3:0]    mins_q, mins_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          heat_q, heat_d;
  logic          done_q, done_d;

  logic time_zero;
  logic last_sec;
  logic key_ok;
  logic run_hold;
  logic tick;
  logic quick_go;
  logic start_go;

  assign time_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign last_sec  = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
  assign key_ok    = panel.key_valid && (panel.key_value <= 4'd9);
  assign run_hold  = panel.stop || !panel.door_closed;
  // A pause request in the wrap cycle swallows the tick.
  assign tick      = (state_q == RUN) && !run_hold && (presc_q == PRESC_MAX);

`ifdef QUICK_START_EN
  assign quick_go = time_zero;
`else
  assign quick_go = 1'b0;
`endif

  assign start_go = panel.start && panel.door_closed && (!time_zero || quick_go);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mins_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
      heat_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mins_q  <= mins_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      heat_q  <= heat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!panel.stop && start_go) state_d = RUN;
      end
      RUN: begin
        if (run_hold)            state_d = PAUSE;
        else if (tick && last_sec) state_d = DONE;
      end
      PAUSE: begin
        if (panel.stop)                              state_d = IDLE;
        else if (panel.start && panel.door_closed)   state_d = RUN;
      end
      DONE: begin
        if (panel.key_valid || panel.start || panel.stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mins_d  = mins_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    heat_d  = (state_d == RUN);
    done_d  = (state_q == RUN) && (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (panel.stop) begin
          mins_d = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (panel.start) begin
          // A start, even an ignored one, outranks a coincident key.
          if (start_go) begin
            presc_d = '0;
            if (time_zero) begin
              mins_d = 4'd0;
              tens_d = 4'd3;
              ones_d = 4'd0;
            end
          end
        end else if (key_ok && (ones_q <= 4'd5)) begin
          mins_d = tens_q;
          tens_d = ones_q;
          ones_d = panel.key_value;
        end
      end
      RUN: begin
        if (!run_hold) begin
          if (tick) begin
            presc_d = '0;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
              tens_d = tens_q - 4'd1;
              ones_d = 4'd9;
            end else begin
              mins_d = mins_q - 4'd1;
              tens_d = 4'd5;
              ones_d = 4'd9;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      PAUSE: begin
        if (panel.stop) begin
          mins_d = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end
      end
      DONE: begin
        mins_d = 4'd0;
        tens_d = 4'd0;
        ones_d = 4'd0;
      end
      default: begin
        mins_d = 4'd0;
        tens_d = 4'd0;
        ones_d = 4'd0;
      end
    endcase
  end

  assign panel.mins     = mins_q;
  assign panel.sec_tens = tens_q;
  assign panel.sec_ones = ones_q;
  assign panel.heat_on  = heat_q;
  assign panel.done     = done_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl: every output change must match the
// next queued expectation, both in value and in the clock cycle it appears.
module tb_microwave_timer_ctrl;
  localparam int CPS = 4;

  logic clk = 1'b0;
  logic reset;

  microwave_timer_ctrl_if u_if();

  microwave_timer_ctrl #(.CLK_PER_SEC(CPS)) dut (
    .clk   (clk),
    .reset (reset),
    .panel (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       heat;
    logic       dn;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [13:0] prev_snap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any change of the visible outputs consumes one expectation.
  always @(negedge clk) begin
    logic [13:0] snap;
    exp_t        e;
    snap = {u_if.mins, u_if.sec_tens, u_if.sec_ones, u_if.heat_on, u_if.done};
    if (mon_en && (snap !== prev_snap)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got %0d:%0d%0d heat=%0b done=%0b required no change",
                 cyc, snap[13:10], snap[9:6], snap[5:2], snap[1], snap[0]);
      end else begin
        e = exp_q.pop_front();
        if ((snap !== {e.m, e.t, e.o, e.heat, e.dn}) || (cyc != e.cyc)) begin
          errors++;
          $display("FAIL output_change got cyc=%0d %0d:%0d%0d heat=%0b done=%0b required cyc=%0d %0d:%0d%0d heat=%0b done=%0b",
                   cyc, snap[13:10], snap[9:6], snap[5:2], snap[1], snap[0],
                   e.cyc, e.m, e.t, e.o, e.heat, e.dn);
        end
      end
    end
    prev_snap = snap;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int c, input int m, input int t, input int o,
                           input logic h, input logic d);
    exp_t e;
    e.cyc  = c;
    e.m    = 4'(m);
    e.t    = 4'(t);
    e.o    = 4'(o);
    e.heat = h;
    e.dn   = d;
    exp_q.push_back(e);
  endtask

  task automatic key(input int v);
    u_if.key_value = 4'(v);
    u_if.key_valid = 1'b1;
    step(1);
    u_if.key_valid = 1'b0;
  endtask

  task automatic key_exp(input int v, input int m, input int t, input int o);
    expect_at(cyc + 1, m, t, o, 1'b0, 1'b0);
    key(v);
  endtask

  task automatic pulse_start();
    u_if.start = 1'b1;
    step(1);
    u_if.start = 1'b0;
  endtask

  task automatic pulse_stop();
    u_if.stop = 1'b1;
    step(1);
    u_if.stop = 1'b0;
  endtask

  task automatic check_direct(input string name, input logic [13:0] req);
    logic [13:0] got;
    got = {u_if.mins, u_if.sec_tens, u_if.sec_ones, u_if.heat_on, u_if.done};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d:%0d%0d heat=%0b done=%0b required %0d:%0d%0d heat=%0b done=%0b",
               name, got[13:10], got[9:6], got[5:2], got[1], got[0],
               req[13:10], req[9:6], req[5:2], req[1], req[0]);
    end
  endtask

  initial begin
    int c;
    int r;
    int s;
    reset            = 1'b1;
    u_if.key_valid   = 1'b0;
    u_if.key_value   = 4'd0;
    u_if.start       = 1'b0;
    u_if.stop        = 1'b0;
    u_if.door_closed = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    check_direct("reset_state", 14'd0);
    mon_en = 1'b1;

    // Entry: 1,3,0 -> 1:30; 7 -> 3:07; 2 ignored (ones > 5)
    key_exp(1, 0, 0, 1);
    key_exp(3, 0, 1, 3);
    key_exp(0, 1, 3, 0);
    key_exp(7, 3, 0, 7);
    key(2);
    step(2);
    expect_at(cyc + 1, 0, 0, 0, 1'b0, 1'b0);
    pulse_stop();
    key(10);
    key(15);
    key_exp(1, 0, 0, 1);
    key_exp(0, 0, 1, 0);
    key_exp(0, 1, 0, 0);

    // Countdown 1:00 -> 0:00, one decrement every CPS cycles
    c = cyc;
    expect_at(c + 1, 1, 0, 0, 1'b1, 1'b0);
    for (int k = 1; k < 60; k++) begin
      s = 60 - k;
      expect_at(c + 1 + CPS * k, s / 60, (s % 60) / 10, s % 10, 1'b1, 1'b0);
    end
    expect_at(c + 1 + CPS * 60, 0, 0, 0, 1'b0, 1'b1);
    expect_at(c + 2 + CPS * 60, 0, 0, 0, 1'b0, 1'b0);
    pulse_start();
    step(CPS * 60 + 5);

    // DONE: first key only returns to IDLE, second is accepted
    key(5);
    key_exp(5, 0, 0, 5);

    // Pause/resume from 0:05 with the door opened mid-second
    c = cyc;
    expect_at(c + 1, 0, 0, 5, 1'b1, 1'b0);
    pulse_start();
    step(2);
    expect_at(c + 4, 0, 0, 5, 1'b0, 1'b0);
    u_if.door_closed = 1'b0;
    step(4);
    u_if.door_closed = 1'b1;
    step(3);
    r = cyc;
    expect_at(r + 1, 0, 0, 5, 1'b1, 1'b0);
    expect_at(r + 3, 0, 0, 4, 1'b1, 1'b0);
    pulse_start();
    step(2);

    // Cancel: stop pauses, second stop clears to IDLE
    expect_at(cyc + 1, 0, 0, 4, 1'b0, 1'b0);
    pulse_stop();
    step(1);
    expect_at(cyc + 1, 0, 0, 0, 1'b0, 1'b0);
    pulse_stop();
    step(1);

    // start+stop together in RUN pauses; key in PAUSE is ignored
    key_exp(3, 0, 0, 3);
    expect_at(cyc + 1, 0, 0, 3, 1'b1, 1'b0);
    pulse_start();
    expect_at(cyc + 1, 0, 0, 3, 1'b0, 1'b0);
    u_if.start = 1'b1;
    u_if.stop  = 1'b1;
    step(1);
    u_if.start = 1'b0;
    u_if.stop  = 1'b0;
    key(1);
    step(1);
    expect_at(cyc + 1, 0, 0, 0, 1'b0, 1'b0);
    pulse_stop();
    step(1);

    // Start at 0:00
`ifdef QUICK_START_EN
    expect_at(cyc + 1, 0, 3, 0, 1'b1, 1'b0);
    pulse_start();
    step(1);
    expect_at(cyc + 1, 0, 3, 0, 1'b0, 1'b0);
    pulse_stop();
    expect_at(cyc + 1, 0, 0, 0, 1'b0, 1'b0);
    pulse_stop();
`else
    pulse_start();
    step(2);
`endif

    // Start with the door open is blocked
    key_exp(2, 0, 0, 2);
    u_if.door_closed = 1'b0;
    pulse_start();
    step(2);
    u_if.door_closed = 1'b1;
    step(1);

    // Asynchronous reset mid-RUN, between clock edges
    c = cyc;
    expect_at(c + 1, 0, 0, 2, 1'b1, 1'b0);
    pulse_start();
    step(2);
    #2;
    expect_at(cyc, 0, 0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_direct("async_reset", 14'd0);
    step(2);
    reset = 1'b0;
    step(1);
    key_exp(1, 0, 0, 1);
    step(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Cooking-timer controller for the oven front panel. Accepts keypad digits into a three-digit BCD time (M:SS), counts it down once per second while cooking, and handles pause, resume and cancel. Its `mins`, `sec_tens` and `sec_ones` outputs drive the seven-segment decoder directly. `heat_on` drives the magnetron enable.

## Interface
Parameters:
- CLK_PER_SEC, default 50_000_000: clock cycles per countdown second (≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  single-cycle strobe; key_value holds a digit.
- key_value  in  4  digit pressed; values >9 are ignored.
- start  in  1  single-cycle start/resume request.
- stop  in  1  single-cycle pause/cancel request.
- door_closed  in  1  level; 1 = door shut.
- mins  out  4  BCD minutes digit (0–9).
- sec_tens  out  4  BCD tens of seconds (0–5).
- sec_ones  out  4  BCD ones of seconds (0–9).
- heat_on  out  1  high only in RUN.
- done  out  1  one-cycle pulse when the countdown reaches 0:00.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values: state IDLE, all digits 0, prescaler 0, heat_on 0, done 0.
- IDLE, key_valid with key_value ≤9:
  - Accepted only if current sec_ones ≤5: mins←sec_tens, sec_tens←sec_ones, sec_ones←key_value; the old mins is discarded.
  - If sec_ones >5 the key is ignored, so sec_tens never exceeds 5.
- IDLE, start, door_closed=1, time ≠0:00: go to RUN and clear the prescaler.
- IDLE, start with time 0:00: ignored (see Configuration).
- IDLE, stop: clear all digits to 0 and stay in IDLE.
- RUN countdown:
  - The prescaler counts 0..CLK_PER_SEC-1; a tick fires on the cycle it wraps.
  - On each tick: if ones>0, ones−1; else if tens>0, tens−1 and ones=9; else mins−1, tens=5, ones=9.
- RUN to DONE: the tick that yields 0:00 moves the state to DONE and pulses done.
- RUN, stop or door_closed=0: go to PAUSE. The prescaler holds its value and no tick fires that cycle.
- PAUSE:
  - start with door_closed=1: back to RUN, with the prescaler resuming from its held value.
  - stop: clear digits and go to IDLE.
  - key_valid: ignored.
- DONE:
  - Digits stay at 0:00.
  - Any of key_valid, start or stop returns to IDLE. That event is consumed and not otherwise acted on.
- Priority when several events occur in the same cycle:
  - stop beats start, start beats key_valid.
  - In RUN, stop or door open beats a coincident tick: the tick is lost and the prescaler holds.
- Door opened in IDLE or PAUSE: no effect except blocking start.

## Timing
- All outputs are registered. Digits change on the clock edge after the accepting event.
- heat_on rises on the edge that enters RUN and falls on the edge that leaves it.
- First decrement after a start from IDLE occurs exactly CLK_PER_SEC cycles after the start edge.
- Countdown from T seconds lasts exactly T×CLK_PER_SEC cycles of RUN time, excluding paused cycles.
- done is high for exactly one cycle, coincident with the first cycle of DONE.
- Reset asserted mid-RUN returns every output to its reset value immediately, without waiting for a clock edge.

## Configuration
- QUICK_START_EN defined: start in IDLE with time 0:00 and door_closed=1 loads 0:30 and enters RUN in the same edge.
- QUICK_START_EN undefined: that start is ignored and the block stays in IDLE at 0:00.

## Test plan
(CLK_PER_SEC=4 for all scenarios)
- Entry:
  - Stimulus: keys 1, 3, 0 in IDLE.
  - Required: digits show 1:30.
  - Then key 7, then key 2: after the 7, digits show 3:07; the 2 is ignored; digits stay 3:07.
- Countdown:
  - Stimulus: load 1:00, then start.
  - Required: heat_on=1; after 4 cycles, 0:59; after 240 cycles, 0:00.
  - Required: done pulses once, state DONE, heat_on=0.
- Pause/resume:
  - Stimulus: from 0:05, open the door 2 cycles after a tick.
  - Required: PAUSE, digits hold, heat_on=0.
  - Stimulus: close the door, then start.
  - Required: the next tick comes 2 cycles later and shows 0:04.
- Cancel:
  - Stimulus: stop in RUN, then stop again.
  - Required: after the second stop, IDLE at 0:00.
  - Stimulus: start and stop in the same cycle while in RUN.
  - Required: goes to PAUSE.
- Quick start:
  - Stimulus: start at 0:00.
  - Required with QUICK_START_EN: RUN at 0:30.
  - Required without it: stays in IDLE at 0:00.
- Reset:
  - Stimulus: assert reset mid-RUN between clock edges.
  - Required: outputs go to 0:00, heat_on=0, done=0 immediately.
